// File: rtl/shift_chain_bist_pkg.sv
// Shared types for the serial delay-chain loopback tester.
// State encoding and counter sizing helper.
package shift_chain_bist_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int w, input int d);
    return $clog2(w + d + 1);
  endfunction

endpackage

// File: rtl/shift_chain_bist.sv
// Loopback sequencer: serialises a word MSB-first onto a delay chain
// and captures the word coming back DEPTH cycles later.
module shift_chain_bist
  import shift_chain_bist_pkg::*;
#(
  parameter int   WIDTH    = 8,
  parameter int   DEPTH    = 8,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] TxData,
  output logic             Ready,
  output logic             ChainIn,
  input  logic             ChainOut,
  output logic [WIDTH-1:0] RxData,
  output logic             Done,
  output logic             Match
);

  localparam int CNT_W = cnt_w(WIDTH, DEPTH);
  localparam int LAST  = WIDTH + DEPTH - 1;

  state_t state, state_nx;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] tx_sh;
  logic [WIDTH-1:0] tx_lat;
  logic [WIDTH-1:0] rx_sh;
  logic [WIDTH-1:0] rx_nx;
  logic             accept;
  logic             run_last;
  logic             tx_more;
  logic             cap;

  assign accept   = Start && (state == S_IDLE);
  assign run_last = (cnt == CNT_W'(LAST));
  assign tx_more  = (int'(cnt) + 1) < WIDTH;
  assign cap      = (state == S_RUN) && (int'(cnt) >= DEPTH);
  assign rx_nx    = WIDTH'({rx_sh, ChainOut});

  always_ff @(posedge Clk) begin
    if (Rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (Start) state_nx = S_RUN;
      S_RUN:   if (run_last) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    Ready = (state == S_IDLE);
    Done  = (state == S_DONE);
  end

  // One counter times both the transmit and the capture window.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt     <= '0;
      tx_sh   <= '0;
      tx_lat  <= '0;
      rx_sh   <= '0;
      RxData  <= '0;
      Match   <= 1'b0;
      ChainIn <= IDLE_BIT;
    end else if (accept) begin
      cnt     <= '0;
      tx_lat  <= TxData;
      tx_sh   <= TxData << 1;
      rx_sh   <= '0;
      ChainIn <= TxData[WIDTH-1];
    end else if (state == S_RUN) begin
      cnt <= cnt + 1'b1;
      if (tx_more) begin
        ChainIn <= tx_sh[WIDTH-1];
        tx_sh   <= tx_sh << 1;
      end else begin
        ChainIn <= IDLE_BIT;
      end
      if (cap) rx_sh <= rx_nx;
      if (run_last) begin
        cnt    <= '0;
        RxData <= rx_nx;
        Match  <= (rx_nx == tx_lat);
      end
    end else begin
      cnt     <= '0;
      ChainIn <= IDLE_BIT;
    end
  end

endmodule

// File: tb/tb_shift_chain_bist.sv
// Bench for shift_chain_bist: vector table, hand-written corner
// sequences and random frames against a behavioural chain model.
module tb_shift_chain_bist;

  localparam int W = 8;
  localparam int D = 8;

  logic         Clk = 1'b0;
  logic         Rst = 1'b0;
  logic         Start = 1'b0;
  logic [W-1:0] TxData = '0;
  logic         Ready;
  logic         ChainIn;
  logic         ChainOut;
  logic [W-1:0] RxData;
  logic         Done;
  logic         Match;

  int total = 0;
  int bad = 0;

  logic [7:0] sr = '0;
  int chain_len = 8;

  always #5 Clk = ~Clk;

  always @(posedge Clk) sr <= {sr[6:0], ChainIn};
  assign ChainOut = sr[chain_len-1];

  shift_chain_bist #(.WIDTH(W), .DEPTH(D), .IDLE_BIT(1'b0)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .TxData(TxData),
    .Ready(Ready), .ChainIn(ChainIn), .ChainOut(ChainOut),
    .RxData(RxData), .Done(Done), .Match(Match)
  );

  typedef struct {
    logic [7:0] tx;
    int         len;
    logic [7:0] rx;
    logic       m;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Value on the chain input in cycle k of a frame carrying d.
  function automatic logic m_chain_in(input logic [7:0] d, input int k);
    if (k >= 1 && k <= W) return d[W-k];
    return 1'b0;
  endfunction

  // Word captured for a frame d through a chain of L stages.
  function automatic logic [7:0] m_rx(input logic [7:0] d, input int L);
    logic [7:0] r = '0;
    for (int i = 0; i < W; i++) begin
      r = {r[6:0], m_chain_in(d, D + i + 1 - L)};
    end
    return r;
  endfunction

  task automatic wait_ready();
    int n = 0;
    @(negedge Clk);
    while (!Ready && n < 40) begin
      @(negedge Clk);
      n++;
    end
    chk("ready_wait", int'(Ready), 1);
  endtask

  // Runs one frame; optional busy poke of Start/3C in cycle 5.
  task automatic do_frame(input logic [7:0] tx, input int len,
                          input logic [7:0] erx, input logic em,
                          input bit poke);
    int nd = 0;
    int dc = 0;
    chain_len = len;
    wait_ready();
    Start = 1'b1;
    TxData = tx;
    @(negedge Clk);
    Start = 1'b0;
    TxData = 8'($urandom);
    for (int k = 1; k <= W + D + 2; k++) begin
      if (k <= W + 2)
        chk($sformatf("chain_in_c%0d", k), int'(ChainIn),
            int'(m_chain_in(tx, k)));
      if (Done) begin
        nd++;
        dc = k;
        chk("rx_data", int'(RxData), int'(erx));
        chk("match", int'(Match), int'(em));
      end
      if (k == W + D + 2) begin
        chk("ready_after", int'(Ready), 1);
        chk("rx_held", int'(RxData), int'(erx));
      end
      if (poke && k == 5) begin
        Start = 1'b1;
        TxData = 8'h3C;
      end
      if (poke && k == 6) Start = 1'b0;
      if (k < W + D + 2) @(negedge Clk);
    end
    chk("done_count", nd, 1);
    chk("done_cycle", dc, W + D + 1);
  endtask

  vec_t tbl[5];

  initial begin
    tbl[0] = '{tx: 8'hA5, len: 8, rx: 8'hA5, m: 1'b1};
    tbl[1] = '{tx: 8'hA5, len: 7, rx: 8'h4A, m: 1'b0};
    tbl[2] = '{tx: 8'h00, len: 8, rx: 8'h00, m: 1'b1};
    tbl[3] = '{tx: 8'hFF, len: 8, rx: 8'hFF, m: 1'b1};
    tbl[4] = '{tx: 8'h3C, len: 6, rx: 8'hF0, m: 1'b0};

    Rst = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("rst_ready", int'(Ready), 1);
    chk("rst_chain_in", int'(ChainIn), 0);
    chk("rst_done", int'(Done), 0);
    chk("rst_rx", int'(RxData), 0);
    chk("rst_match", int'(Match), 0);
    Rst = 1'b0;

    foreach (tbl[i]) do_frame(tbl[i].tx, tbl[i].len, tbl[i].rx, tbl[i].m, 1'b0);

    do_frame(8'hA5, 8, 8'hA5, 1'b1, 1'b1);

    // Reset in cycle 6 of a frame, then a clean frame.
    chain_len = 8;
    wait_ready();
    Start = 1'b1;
    TxData = 8'hA5;
    @(negedge Clk);
    Start = 1'b0;
    repeat (5) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    chk("mid_rst_ready", int'(Ready), 1);
    chk("mid_rst_chain_in", int'(ChainIn), 0);
    chk("mid_rst_rx", int'(RxData), 0);
    chk("mid_rst_match", int'(Match), 0);
    begin
      int nd = 0;
      for (int k = 0; k < 20; k++) begin
        if (Done) nd++;
        @(negedge Clk);
      end
      chk("mid_rst_no_done", nd, 0);
    end
    do_frame(8'hFF, 8, 8'hFF, 1'b1, 1'b0);

    // Back-to-back with Start held high.
    wait_ready();
    Start = 1'b1;
    TxData = 8'h01;
    @(negedge Clk);
    TxData = 8'h80;
    begin
      int dcs[$];
      logic [7:0] rxs[$];
      logic ms[$];
      for (int k = 1; k <= 36; k++) begin
        if (Done) begin
          dcs.push_back(k);
          rxs.push_back(RxData);
          ms.push_back(Match);
        end
        if (k == 19) Start = 1'b0;
        @(negedge Clk);
      end
      chk("b2b_done_n", dcs.size(), 2);
      if (dcs.size() == 2) begin
        chk("b2b_done0", dcs[0], 17);
        chk("b2b_done1", dcs[1], 35);
        chk("b2b_rx0", int'(rxs[0]), 8'h01);
        chk("b2b_rx1", int'(rxs[1]), 8'h80);
        chk("b2b_m0", int'(ms[0]), 1);
        chk("b2b_m1", int'(ms[1]), 1);
      end
    end

    for (int n = 0; n < 20; n++) begin
      logic [7:0] tx;
      int len;
      logic [7:0] e;
      tx = 8'($urandom);
      len = int'($urandom_range(6, 8));
      e = m_rx(tx, len);
      repeat ($urandom_range(0, 3)) @(negedge Clk);
      do_frame(tx, len, e, e == tx, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
